// File: rtl/prienc_pkg.sv
// Shared types and helpers for the iterative priority encoder.
// The top module selects MSB-first order when PRIENC_MSB_FIRST_EN is defined.
package prienc_pkg;

  // Upper bound on the request width that onehot_is_single() can inspect.
  localparam int PRIENC_MAX_W = 1024;
  localparam logic [PRIENC_MAX_W-1:0] PRIENC_ONE = {{(PRIENC_MAX_W-1){1'b0}}, 1'b1};

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } prienc_state_t;

  // True when exactly one bit of vec is set.
  // Clearing the lowest set bit leaves zero only for a power of two.
  function automatic logic onehot_is_single(input logic [PRIENC_MAX_W-1:0] vec);
    return (vec != '0) && ((vec & (vec - PRIENC_ONE)) == '0);
  endfunction

endpackage

// File: rtl/prienc_ffs.sv
// Combinational find-first-set over a WIDTH-bit vector.
// MSB_FIRST=0 picks the lowest set bit; MSB_FIRST=1 picks the highest.
module prienc_ffs #(
  parameter int  WIDTH     = 8,
  parameter bit  MSB_FIRST = 1'b0,
  localparam int IDX_W     = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // The loop walks from lowest to highest priority.
  // The last hit therefore overwrites any earlier one and wins.
  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves it unassigned and no latch is inferred.
    idx   = '0;
    found = |vec;
    for (int i = 0; i < WIDTH; i++) begin
      int j;
      j = MSB_FIRST ? i : (WIDTH - 1 - i);
      if (vec[j]) idx = IDX_W'(j);
    end
  end

endmodule

// File: rtl/priority_encoder_iter.sv
// Serialises a captured request vector into one index per beat over valid/ready.
// Order is LSB-first, or MSB-first when PRIENC_MSB_FIRST_EN is defined.
module priority_encoder_iter
  import prienc_pkg::*;
#(
  parameter int  WIDTH = 8,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             busy
);

`ifdef PRIENC_MSB_FIRST_EN
  localparam bit MSB_FIRST = 1'b1;
`else
  localparam bit MSB_FIRST = 1'b0;
`endif

  prienc_state_t     state, state_next;
  logic [WIDTH-1:0]  pend, pend_next;
  logic [IDX_W-1:0]  ffs_idx;
  logic              ffs_found;
  logic              pend_single;
  logic [PRIENC_MAX_W-1:0] pend_ext;

  prienc_ffs #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_ffs (
    .vec   (pend),
    .idx   (ffs_idx),
    .found (ffs_found)
  );

  assign pend_ext    = {{(PRIENC_MAX_W-WIDTH){1'b0}}, pend};
  assign pend_single = onehot_is_single(pend_ext);

  // Outputs are forced to zero outside SCAN so they never carry stale or X values.
  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == SCAN);
  assign busy      = (state == SCAN);
  assign out_idx   = out_valid ? ffs_idx : '0;
  assign out_last  = out_valid && pend_single;

  always_comb begin
    state_next = state;
    pend_next  = pend;
    unique case (state)
      IDLE: begin
        // An all-zero vector is consumed without producing beats.
        if (in_valid && in_ready && (in_vec != '0)) begin
          pend_next  = in_vec;
          state_next = SCAN;
        end
      end
      SCAN: begin
        if (out_ready && ffs_found) begin
          pend_next[ffs_idx] = 1'b0;
          if (pend_single) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register updating from pre-edge values.
    if (rst) begin
      state <= IDLE;
      pend  <= '0;
    end else begin
      state <= state_next;
      pend  <= pend_next;
    end
  end

endmodule

// File: tb/tb_priority_encoder_iter.sv
// Directed self-checking bench for priority_encoder_iter (WIDTH=8).
// Expected orders follow PRIENC_MSB_FIRST_EN when it is defined.
module tb_priority_encoder_iter;

`ifdef PRIENC_MSB_FIRST_EN
  localparam bit MSB = 1'b1;
  // Expected beats packed one per nibble, first beat in the low nibble.
  localparam logic [31:0] SEQ_A4 = 32'h0000_0257;
  localparam logic [31:0] SEQ_81 = 32'h0000_0007;
  localparam logic [31:0] SEQ_80 = 32'h0000_0007;
  localparam logic [31:0] SEQ_13 = 32'h0000_0014;
  localparam logic [31:0] FIRST_0F = 32'd3;
`else
  localparam bit MSB = 1'b0;
  localparam logic [31:0] SEQ_A4 = 32'h0000_0752;
  localparam logic [31:0] SEQ_81 = 32'h0000_0070;
  localparam logic [31:0] SEQ_80 = 32'h0000_0007;
  localparam logic [31:0] SEQ_13 = 32'h0000_0410;
  localparam logic [31:0] FIRST_0F = 32'd0;
`endif

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_vec;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_idx;
  logic       out_last;
  logic       busy;

  int         n_total;
  int         n_pass;
  int         e;
  logic [3:0] pat;

  priority_encoder_iter #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expects n back-to-back beats with out_ready=1, then the idle cycle.
  task automatic drain(input string tag, input logic [31:0] seq, input int n);
    for (int k = 0; k < n; k++) begin
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_busy"},  32'(busy),      32'd1);
      check({tag, "_idx"},   32'(out_idx),   32'(seq[4*k +: 3]));
      check({tag, "_last"},  32'(out_last),  32'(k == n - 1));
      tick();
    end
    check({tag, "_end_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_end_ready"}, 32'(in_ready),  32'd1);
  endtask

  initial begin
    n_total   = 0;
    n_pass    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_vec    = 8'h00;
    out_ready = 1'b1;
    pat       = 4'b1001;

    // Reset state.
    tick();
    tick();
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_out_idx",   32'(out_idx),   32'd0);
    check("rst_out_last",  32'(out_last),  32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(in_ready), 32'd1);

    // Basic vector 1010_0100.
    in_vec   = 8'hA4;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("a4_in_ready", 32'(in_ready), 32'd0);
    drain("a4", SEQ_A4, 3);

    // Empty vector is discarded; the next vector is taken the following cycle.
    in_vec   = 8'h00;
    in_valid = 1'b1;
    tick();
    check("zero_valid", 32'(out_valid), 32'd0);
    check("zero_ready", 32'(in_ready),  32'd1);
    check("zero_busy",  32'(busy),      32'd0);
    in_vec = 8'h81;
    tick();
    // Offer a different vector while scanning; it must not be captured.
    in_vec = 8'h7E;
    drain("x81", SEQ_81, 2);
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("x7e_ignored", 32'(out_valid), 32'd0);
    end

    // All-ones with out_ready pattern 1,0,0,1 repeating.
    in_vec   = 8'hFF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    e = 0;
    for (int c = 0; c < 40 && e < 8; c++) begin
      check("ff_valid", 32'(out_valid), 32'd1);
      check("ff_idx",   32'(out_idx),   MSB ? 32'(7 - e) : 32'(e));
      check("ff_last",  32'(out_last),  32'(e == 7));
      out_ready = pat[c % 4];
      if (out_ready) e++;
      tick();
    end
    out_ready = 1'b1;
    check("ff_count",     32'(e),         32'd8);
    check("ff_end_valid", 32'(out_valid), 32'd0);
    check("ff_end_ready", 32'(in_ready),  32'd1);

    // Single bit at the top index.
    in_vec   = 8'h80;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    drain("x80", SEQ_80, 1);

    // Reset aborts a vector after its first beat is presented.
    in_vec   = 8'h0F;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("abort_first", 32'(out_idx), FIRST_0F);
    rst = 1'b1;
    tick();
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_busy",  32'(busy),      32'd0);
    check("abort_ready", 32'(in_ready),  32'd0);
    check("abort_idx",   32'(out_idx),   32'd0);
    rst = 1'b0;
    #1;
    check("abort_ready_rel", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort_no_beat", 32'(out_valid), 32'd0);
    end

    // Vector 0001_0011: order depends on the build.
    in_vec   = 8'h13;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    drain("x13", SEQ_13, 3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
